// File: rtl/ris_sweep_scheduler_if.sv
// Host/TX-side bundle for the RIS sweep scheduler: table load, sweep control,
// the GPIO pattern output and the tx_req/tx_ack handshake towards the serializer.
interface ris_sweep_scheduler_if #(
    parameter int ADDR_W  = 4,
    parameter int DWELL_W = 24
);
    logic               wr_en;
    logic [ADDR_W-1:0]  wr_addr;
    logic [31:0]        wr_data;
    logic [ADDR_W-1:0]  last_idx;
    logic [DWELL_W-1:0] dwell;
    logic               loop_en;
    logic               start;
    logic               stop;
    logic               tx_ack;
    logic [31:0]        Ctl_Gpio;
    logic               tx_req;
    logic [31:0]        tx_data;
    logic [ADDR_W-1:0]  pat_idx;
    logic               busy;
    logic               done;

    modport master (
        output wr_en, wr_addr, wr_data, last_idx, dwell, loop_en, start, stop, tx_ack,
        input  Ctl_Gpio, tx_req, tx_data, pat_idx, busy, done
    );

    modport slave (
        input  wr_en, wr_addr, wr_data, last_idx, dwell, loop_en, start, stop, tx_ack,
        output Ctl_Gpio, tx_req, tx_data, pat_idx, busy, done
    );
endinterface

// File: rtl/ris_sweep_scheduler.sv
// Steps through a pattern table onto Ctl_Gpio; first pattern 2 edges after start.
// Holds tx_req until tx_ack (no timeout), then dwells before the next pattern.
module ris_sweep_scheduler #(
    parameter int ADDR_W  = 4,
    parameter int DWELL_W = 24
) (
    input  logic                  CLOCK_50,
    input  logic                  reset,
    ris_sweep_scheduler_if.slave  bus
);
    typedef enum logic [2:0] {
        S_IDLE,
        S_LOAD,
        S_APPLY,
        S_REPORT,
        S_DWELL
    } state_t;

    state_t             state_q, state_d;
    logic [ADDR_W-1:0]  idx_q, idx_d;
    logic [ADDR_W-1:0]  last_q, last_d;
    logic [ADDR_W-1:0]  pat_idx_q, pat_idx_d;
    logic [DWELL_W-1:0] dwell_q, dwell_d;
    logic [DWELL_W-1:0] cnt_q, cnt_d;
    logic               loop_q, loop_d;
    logic               stop_pend_q, stop_pend_d;
    logic               tx_req_q, tx_req_d;
    logic               done_q, done_d;
    logic [31:0]        ctl_gpio_q, ctl_gpio_d;
    logic [31:0]        tx_data_q, tx_data_d;
    logic [31:0]        rd_q;
    logic [31:0]        mem [2**ADDR_W];

    // Table has no reset so its contents survive a reset pulse.
    always_ff @(posedge CLOCK_50) begin
        if (bus.wr_en && state_q == S_IDLE) begin
            mem[bus.wr_addr] <= bus.wr_data;
        end
        if (state_q == S_LOAD) begin
            rd_q <= mem[idx_q];
        end
    end

    always_comb begin
        state_d     = state_q;
        idx_d       = idx_q;
        last_d      = last_q;
        pat_idx_d   = pat_idx_q;
        dwell_d     = dwell_q;
        cnt_d       = cnt_q;
        loop_d      = loop_q;
        stop_pend_d = stop_pend_q;
        tx_req_d    = tx_req_q;
        done_d      = 1'b0;
        ctl_gpio_d  = ctl_gpio_q;
        tx_data_d   = tx_data_q;

        unique case (state_q)
            S_IDLE: begin
                if (bus.start && !bus.stop) begin
                    idx_d       = '0;
                    last_d      = bus.last_idx;
                    loop_d      = bus.loop_en;
                    dwell_d     = (bus.dwell == '0) ? DWELL_W'(1) : bus.dwell;
                    stop_pend_d = 1'b0;
                    state_d     = S_LOAD;
                end
            end
            S_LOAD: begin
                state_d = bus.stop ? S_IDLE : S_APPLY;
            end
            S_APPLY: begin
                if (bus.stop) begin
                    state_d = S_IDLE;
                end else begin
                    ctl_gpio_d = rd_q;
                    tx_data_d  = rd_q;
                    pat_idx_d  = idx_q;
                    tx_req_d   = 1'b1;
                    state_d    = S_REPORT;
                end
            end
            S_REPORT: begin
                // A stop here must not cut the handshake short; remember it.
                if (bus.stop) begin
                    stop_pend_d = 1'b1;
                end
                if (bus.tx_ack) begin
                    tx_req_d = 1'b0;
                    cnt_d    = dwell_q - DWELL_W'(1);
                    state_d  = (stop_pend_q || bus.stop) ? S_IDLE : S_DWELL;
                end
            end
            S_DWELL: begin
                if (bus.stop) begin
                    state_d = S_IDLE;
                end else if (cnt_q != '0) begin
                    cnt_d = cnt_q - DWELL_W'(1);
                end else if (idx_q != last_q) begin
                    idx_d   = idx_q + ADDR_W'(1);
                    state_d = S_LOAD;
                end else if (loop_q) begin
                    idx_d   = '0;
                    state_d = S_LOAD;
                end else begin
                    done_d  = 1'b1;
                    state_d = S_IDLE;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge CLOCK_50) begin
        if (!reset) begin
            state_q     <= S_IDLE;
            idx_q       <= '0;
            last_q      <= '0;
            pat_idx_q   <= '0;
            dwell_q     <= DWELL_W'(1);
            cnt_q       <= '0;
            loop_q      <= 1'b0;
            stop_pend_q <= 1'b0;
            tx_req_q    <= 1'b0;
            done_q      <= 1'b0;
            ctl_gpio_q  <= '0;
            tx_data_q   <= '0;
        end else begin
            state_q     <= state_d;
            idx_q       <= idx_d;
            last_q      <= last_d;
            pat_idx_q   <= pat_idx_d;
            dwell_q     <= dwell_d;
            cnt_q       <= cnt_d;
            loop_q      <= loop_d;
            stop_pend_q <= stop_pend_d;
            tx_req_q    <= tx_req_d;
            done_q      <= done_d;
            ctl_gpio_q  <= ctl_gpio_d;
            tx_data_q   <= tx_data_d;
        end
    end

    assign bus.Ctl_Gpio = ctl_gpio_q;
    assign bus.tx_req   = tx_req_q;
    assign bus.tx_data  = tx_data_q;
    assign bus.pat_idx  = pat_idx_q;
    assign bus.busy     = (state_q != S_IDLE);
    assign bus.done     = done_q;
endmodule

// File: tb/tb_ris_sweep_scheduler.sv
// Bench for ris_sweep_scheduler: a TX responder with configurable ack delay, an
// apply-event monitor, and a table/period model of each sweep.
module tb_ris_sweep_scheduler;
    localparam int ADDR_W  = 4;
    localparam int DWELL_W = 24;
    localparam int DEPTH   = 16;

    logic clk   = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    ris_sweep_scheduler_if #(.ADDR_W(ADDR_W), .DWELL_W(DWELL_W)) ifc ();

    ris_sweep_scheduler #(.ADDR_W(ADDR_W), .DWELL_W(DWELL_W)) dut (
        .CLOCK_50 (clk),
        .reset    (rst_n),
        .bus      (ifc)
    );

    int          checks   = 0;
    int          failures = 0;
    int          cyc      = 0;
    logic [31:0] tb_mem [DEPTH];

    // Monitor state: one entry per tx_req rising edge (a pattern being applied).
    int          ev_cycle [$];
    logic [31:0] ev_pat   [$];
    logic [31:0] ev_txd   [$];
    int          ev_idx   [$];
    logic        prev_req     = 1'b0;
    logic        prev_done    = 1'b0;
    int          req_age      = 0;
    int          ack_wait     = 0;
    logic [31:0] txd_hold     = '0;
    logic        txd_changed  = 1'b0;
    int          last_run     = 0;
    logic        busy_at_fall = 1'b0;
    int          done_cnt     = 0;
    logic        done_long    = 1'b0;

    function automatic int exp_period(input int dw, input int w);
        return 3 + w + ((dw == 0) ? 1 : dw);
    endfunction

    task automatic step();
        @(negedge clk);
        cyc++;
        if (ifc.tx_req && !prev_req) begin
            ev_cycle.push_back(cyc);
            ev_pat.push_back(ifc.Ctl_Gpio);
            ev_txd.push_back(ifc.tx_data);
            ev_idx.push_back(int'(ifc.pat_idx));
            req_age  = 0;
            txd_hold = ifc.tx_data;
        end
        if (ifc.tx_req) begin
            req_age++;
            if (ifc.tx_data !== txd_hold) txd_changed = 1'b1;
        end
        if (!ifc.tx_req && prev_req) begin
            last_run     = req_age;
            busy_at_fall = ifc.busy;
        end
        if (ifc.done) done_cnt++;
        if (ifc.done && prev_done) done_long = 1'b1;
        prev_req   = ifc.tx_req;
        prev_done  = ifc.done;
        ifc.tx_ack = ifc.tx_req && (req_age > ack_wait);
    endtask

    task automatic clear_mon();
        ev_cycle.delete(); ev_pat.delete(); ev_txd.delete(); ev_idx.delete();
        txd_changed = 1'b0;
        done_cnt    = 0;
        done_long   = 1'b0;
        last_run    = 0;
    endtask

    task automatic write_word(input int addr, input logic [31:0] data);
        ifc.wr_en   = 1'b1;
        ifc.wr_addr = ADDR_W'(addr);
        ifc.wr_data = data;
        step();
        ifc.wr_en   = 1'b0;
    endtask

    task automatic do_start(input int last, input int dw, input bit lp, output int s_cyc);
        ifc.last_idx = ADDR_W'(last);
        ifc.dwell    = DWELL_W'(dw);
        ifc.loop_en  = lp;
        ifc.start    = 1'b1;
        s_cyc        = cyc;
        step();
        ifc.start    = 1'b0;
    endtask

    task automatic wait_idle(input int budget, output bit ok);
        ok = 1'b0;
        for (int i = 0; i < budget; i++) begin
            step();
            if (!ifc.busy) begin
                ok = 1'b1;
                break;
            end
        end
    endtask

    task automatic wait_events(input int n, input int budget, output bit ok);
        ok = 1'b0;
        for (int i = 0; i < budget; i++) begin
            step();
            if (ev_pat.size() >= n) begin
                ok = 1'b1;
                break;
            end
        end
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        repeat (3) step();
        checks++; if (ifc.Ctl_Gpio !== 32'h0) begin failures++; $display("FAIL reset_ctl got=%h exp=0", ifc.Ctl_Gpio); end
        checks++; if (ifc.tx_req !== 1'b0) begin failures++; $display("FAIL reset_tx_req got=%b exp=0", ifc.tx_req); end
        checks++; if (ifc.tx_data !== 32'h0) begin failures++; $display("FAIL reset_tx_data got=%h exp=0", ifc.tx_data); end
        checks++; if (ifc.pat_idx !== '0) begin failures++; $display("FAIL reset_pat_idx got=%0d exp=0", ifc.pat_idx); end
        checks++; if (ifc.busy !== 1'b0) begin failures++; $display("FAIL reset_busy got=%b exp=0", ifc.busy); end
        checks++; if (ifc.done !== 1'b0) begin failures++; $display("FAIL reset_done got=%b exp=0", ifc.done); end
        rst_n = 1'b1;
        step();
    endtask

    task automatic test_basic_sweep();
        int s; bit ok;
        tb_mem[0] = 32'hAAAA0001; tb_mem[1] = 32'h55550002; tb_mem[2] = 32'h0000FFFF;
        for (int a = 0; a < 3; a++) write_word(a, tb_mem[a]);
        ack_wait = 0;
        clear_mon();
        do_start(2, 10, 1'b0, s);
        wait_idle(400, ok);
        checks++; if (!ok) begin failures++; $display("FAIL basic_timeout busy=%b exp=0", ifc.busy); end
        checks++; if (ev_pat.size() != 3) begin failures++; $display("FAIL basic_count got=%0d exp=3", ev_pat.size()); end
        if (ev_cycle.size() > 0) begin
            checks++; if (ev_cycle[0] != s + 3) begin failures++; $display("FAIL basic_latency got=%0d exp=%0d", ev_cycle[0] - s, 3); end
        end
        for (int k = 0; k < ev_pat.size() && k < 3; k++) begin
            checks++; if (ev_pat[k] !== tb_mem[k]) begin failures++; $display("FAIL basic_pat%0d got=%h exp=%h", k, ev_pat[k], tb_mem[k]); end
            checks++; if (ev_txd[k] !== tb_mem[k]) begin failures++; $display("FAIL basic_txd%0d got=%h exp=%h", k, ev_txd[k], tb_mem[k]); end
            checks++; if (ev_idx[k] != k) begin failures++; $display("FAIL basic_idx%0d got=%0d exp=%0d", k, ev_idx[k], k); end
            if (k > 0) begin
                checks++;
                if (ev_cycle[k] - ev_cycle[k-1] != exp_period(10, 0)) begin
                    failures++; $display("FAIL basic_period%0d got=%0d exp=%0d", k, ev_cycle[k] - ev_cycle[k-1], exp_period(10, 0));
                end
            end
        end
        checks++; if (done_cnt != 1 || done_long) begin failures++; $display("FAIL basic_done got=%0d long=%b exp=1", done_cnt, done_long); end
        checks++; if (ifc.Ctl_Gpio !== tb_mem[2]) begin failures++; $display("FAIL basic_hold got=%h exp=%h", ifc.Ctl_Gpio, tb_mem[2]); end
    endtask

    task automatic test_loop_stop();
        int s; bit ok;
        ack_wait = 0;
        clear_mon();
        do_start(2, 0, 1'b1, s);
        wait_events(6, 200, ok);
        checks++; if (!ok) begin failures++; $display("FAIL loop_timeout events=%0d exp=6", ev_pat.size()); end
        step();
        ifc.stop = 1'b1;
        step();
        ifc.stop = 1'b0;
        repeat (6) step();
        checks++; if (ev_pat.size() != 6) begin failures++; $display("FAIL loop_count got=%0d exp=6", ev_pat.size()); end
        for (int k = 0; k < ev_pat.size() && k < 6; k++) begin
            checks++; if (ev_idx[k] != k % 3) begin failures++; $display("FAIL loop_idx%0d got=%0d exp=%0d", k, ev_idx[k], k % 3); end
            checks++; if (ev_pat[k] !== tb_mem[k % 3]) begin failures++; $display("FAIL loop_pat%0d got=%h exp=%h", k, ev_pat[k], tb_mem[k % 3]); end
            if (k > 0) begin
                checks++;
                if (ev_cycle[k] - ev_cycle[k-1] != exp_period(0, 0)) begin
                    failures++; $display("FAIL loop_period%0d got=%0d exp=%0d", k, ev_cycle[k] - ev_cycle[k-1], exp_period(0, 0));
                end
            end
        end
        checks++; if (done_cnt != 0) begin failures++; $display("FAIL loop_done got=%0d exp=0", done_cnt); end
        checks++; if (ifc.busy !== 1'b0) begin failures++; $display("FAIL loop_stop_busy got=%b exp=0", ifc.busy); end
        checks++; if (ifc.Ctl_Gpio !== tb_mem[2]) begin failures++; $display("FAIL loop_hold got=%h exp=%h", ifc.Ctl_Gpio, tb_mem[2]); end
    endtask

    task automatic test_stop_in_report();
        int s; bit ok; bit ok2;
        ack_wait = 50;
        clear_mon();
        do_start(2, 10, 1'b0, s);
        wait_events(1, 20, ok);
        checks++; if (!ok) begin failures++; $display("FAIL rstop_timeout events=%0d exp=1", ev_pat.size()); end
        ifc.stop = 1'b1;
        step();
        ifc.stop = 1'b0;
        wait_idle(200, ok2);
        checks++; if (!ok2) begin failures++; $display("FAIL rstop_idle_timeout busy=%b exp=0", ifc.busy); end
        checks++; if (last_run != 51) begin failures++; $display("FAIL rstop_req_len got=%0d exp=51", last_run); end
        checks++; if (txd_changed) begin failures++; $display("FAIL rstop_txd_stable got=changed exp=stable"); end
        checks++; if (busy_at_fall !== 1'b0) begin failures++; $display("FAIL rstop_idle_after_ack got=%b exp=0", busy_at_fall); end
        checks++; if (ev_pat.size() != 1) begin failures++; $display("FAIL rstop_count got=%0d exp=1", ev_pat.size()); end
        checks++; if (done_cnt != 0) begin failures++; $display("FAIL rstop_done got=%0d exp=0", done_cnt); end
        ack_wait = 0;
    endtask

    task automatic test_start_stop_wr();
        int s; bit ok;
        clear_mon();
        ifc.start = 1'b1; ifc.stop = 1'b1;
        step();
        ifc.start = 1'b0; ifc.stop = 1'b0;
        step();
        checks++; if (ifc.busy !== 1'b0) begin failures++; $display("FAIL startstop_busy got=%b exp=0", ifc.busy); end
        do_start(2, 10, 1'b0, s);
        wait_events(1, 20, ok);
        write_word(1, 32'h12345678);
        wait_idle(400, ok);
        checks++; if (!ok) begin failures++; $display("FAIL wrbusy_timeout busy=%b exp=0", ifc.busy); end
        checks++; if (ev_pat.size() != 3) begin failures++; $display("FAIL wrbusy_count got=%0d exp=3", ev_pat.size()); end
        clear_mon();
        do_start(2, 2, 1'b0, s);
        wait_idle(200, ok);
        checks++; if (ev_pat.size() < 2 || ev_pat[1] !== tb_mem[1]) begin
            failures++; $display("FAIL wrbusy_table got=%h exp=%h", (ev_pat.size() > 1) ? ev_pat[1] : 32'hx, tb_mem[1]);
        end
    endtask

    task automatic test_latch();
        int s; bit ok;
        clear_mon();
        do_start(2, 10, 1'b0, s);
        wait_events(1, 20, ok);
        ifc.dwell = DWELL_W'(1000); ifc.last_idx = '0; ifc.loop_en = 1'b1;
        wait_idle(400, ok);
        checks++; if (!ok) begin failures++; $display("FAIL latch_timeout busy=%b exp=0", ifc.busy); end
        checks++; if (ev_pat.size() != 3) begin failures++; $display("FAIL latch_count got=%0d exp=3", ev_pat.size()); end
        for (int k = 1; k < ev_cycle.size() && k < 3; k++) begin
            checks++;
            if (ev_cycle[k] - ev_cycle[k-1] != exp_period(10, 0)) begin
                failures++; $display("FAIL latch_period%0d got=%0d exp=%0d", k, ev_cycle[k] - ev_cycle[k-1], exp_period(10, 0));
            end
        end
        checks++; if (done_cnt != 1) begin failures++; $display("FAIL latch_done got=%0d exp=1", done_cnt); end
        clear_mon();
        do_start(0, 10, 1'b0, s);
        wait_idle(200, ok);
        checks++; if (ev_pat.size() != 1) begin failures++; $display("FAIL single_count got=%0d exp=1", ev_pat.size()); end
        checks++; if (ev_pat.size() > 0 && ev_pat[0] !== tb_mem[0]) begin failures++; $display("FAIL single_pat got=%h exp=%h", ev_pat[0], tb_mem[0]); end
        checks++; if (done_cnt != 1) begin failures++; $display("FAIL single_done got=%0d exp=1", done_cnt); end
    endtask

    task automatic test_random();
        int s; bit ok; int last; int dw; int n;
        for (int it = 0; it < 4; it++) begin
            for (int a = 0; a < DEPTH; a++) begin
                tb_mem[a] = $urandom;
                write_word(a, tb_mem[a]);
            end
            last     = $urandom_range(0, 4);
            dw       = $urandom_range(0, 5);
            ack_wait = $urandom_range(0, 3);
            clear_mon();
            do_start(last, dw, 1'b0, s);
            wait_idle(500, ok);
            n = last + 1;
            checks++; if (!ok || ev_pat.size() != n) begin failures++; $display("FAIL rand%0d_count got=%0d exp=%0d", it, ev_pat.size(), n); end
            for (int k = 0; k < ev_pat.size() && k < n; k++) begin
                checks++;
                if (ev_pat[k] !== tb_mem[k] || ev_idx[k] != k) begin
                    failures++; $display("FAIL rand%0d_pat%0d got=%h/%0d exp=%h/%0d", it, k, ev_pat[k], ev_idx[k], tb_mem[k], k);
                end
                if (k > 0) begin
                    checks++;
                    if (ev_cycle[k] - ev_cycle[k-1] != exp_period(dw, ack_wait)) begin
                        failures++; $display("FAIL rand%0d_period%0d got=%0d exp=%0d", it, k, ev_cycle[k] - ev_cycle[k-1], exp_period(dw, ack_wait));
                    end
                end
            end
            checks++; if (done_cnt != 1) begin failures++; $display("FAIL rand%0d_done got=%0d exp=1", it, done_cnt); end
        end
        ack_wait = 0;
    endtask

    task automatic test_reset_mid();
        int s; bit ok;
        ack_wait = 1000;
        clear_mon();
        do_start(2, 10, 1'b0, s);
        wait_events(1, 20, ok);
        checks++; if (!ok) begin failures++; $display("FAIL rmid_timeout events=%0d exp=1", ev_pat.size()); end
        rst_n = 1'b0;
        step();
        checks++; if (ifc.tx_req !== 1'b0) begin failures++; $display("FAIL rmid_tx_req got=%b exp=0", ifc.tx_req); end
        checks++; if (ifc.Ctl_Gpio !== 32'h0) begin failures++; $display("FAIL rmid_ctl got=%h exp=0", ifc.Ctl_Gpio); end
        checks++; if (ifc.busy !== 1'b0) begin failures++; $display("FAIL rmid_busy got=%b exp=0", ifc.busy); end
        checks++; if (ifc.tx_data !== 32'h0) begin failures++; $display("FAIL rmid_tx_data got=%h exp=0", ifc.tx_data); end
        rst_n    = 1'b1;
        ack_wait = 0;
        step();
        clear_mon();
        do_start(2, 3, 1'b0, s);
        wait_idle(200, ok);
        checks++; if (ev_pat.size() != 3) begin failures++; $display("FAIL rmid_resweep_count got=%0d exp=3", ev_pat.size()); end
        for (int k = 0; k < ev_pat.size() && k < 3; k++) begin
            checks++; if (ev_pat[k] !== tb_mem[k]) begin failures++; $display("FAIL rmid_pat%0d got=%h exp=%h", k, ev_pat[k], tb_mem[k]); end
        end
    endtask

    initial begin
        ifc.wr_en = 1'b0; ifc.wr_addr = '0; ifc.wr_data = '0;
        ifc.last_idx = '0; ifc.dwell = '0; ifc.loop_en = 1'b0;
        ifc.start = 1'b0; ifc.stop = 1'b0; ifc.tx_ack = 1'b0;
        test_reset();
        test_basic_sweep();
        test_loop_stop();
        test_stop_in_report();
        test_start_stop_wr();
        test_latch();
        test_random();
        test_reset_mid();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
